// File: rtl/multicycle_control_fsm.sv
// Sequencing controller for the multicycle MIPS core: walks fetch/decode/execute/mem/writeback,
// stalls on the memory ready handshake, and flags illegal opcodes and memory timeouts.
module multicycle_control_fsm #(
  parameter int unsigned OPCODE_WIDTH = 6,
  parameter int unsigned ALU_OP_WIDTH = 2,
  parameter int unsigned WAIT_WIDTH   = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  input  logic                    i_zero,
  input  logic                    i_mem_ready,
  output logic                    o_pc_en_c,
  output logic                    o_iord,
  output logic                    o_mem_write,
  output logic                    o_ir_write_c,
  output logic                    o_reg_dst,
  output logic                    o_mem_to_reg,
  output logic                    o_reg_write,
  output logic                    o_alu_src_a,
  output logic [1:0]              o_alu_src_b,
  output logic [ALU_OP_WIDTH-1:0] o_alu_op,
  output logic [1:0]              o_pc_src,
  output logic                    o_instr_done,
  output logic                    o_illegal_op,
  output logic                    o_mem_err
);

  localparam logic [OPCODE_WIDTH-1:0] OP_LW   = OPCODE_WIDTH'(6'b100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_SW   = OPCODE_WIDTH'(6'b101011);
  localparam logic [OPCODE_WIDTH-1:0] OP_R    = OPCODE_WIDTH'(6'b000000);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(6'b001000);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = OPCODE_WIDTH'(6'b000100);
  localparam logic [OPCODE_WIDTH-1:0] OP_J    = OPCODE_WIDTH'(6'b000010);

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD   = ALU_OP_WIDTH'(2'b00);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB   = ALU_OP_WIDTH'(2'b01);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_FUNCT = ALU_OP_WIDTH'(2'b10);

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMX4 = 2'b11;

  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_BEQ    = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [WAIT_WIDTH-1:0]   r_wait;
  logic [WAIT_WIDTH-1:0]   w_wait_inc;
  logic                    r_is_sw;
  logic                    w_wait_state;
  logic                    w_timeout;
  logic                    w_retire;
  logic                    w_illegal;

  logic                    r_iord;
  logic                    r_mem_write;
  logic                    r_reg_dst;
  logic                    r_mem_to_reg;
  logic                    r_reg_write;
  logic                    r_alu_src_a;
  logic [1:0]              r_alu_src_b;
  logic [ALU_OP_WIDTH-1:0] r_alu_op;
  logic [1:0]              r_pc_src;
  logic                    r_instr_done;
  logic                    r_illegal_op;
  logic                    r_mem_err;

  logic                    w_iord_nxt;
  logic                    w_mem_write_nxt;
  logic                    w_reg_dst_nxt;
  logic                    w_mem_to_reg_nxt;
  logic                    w_reg_write_nxt;
  logic                    w_alu_src_a_nxt;
  logic [1:0]              w_alu_src_b_nxt;
  logic [ALU_OP_WIDTH-1:0] w_alu_op_nxt;
  logic [1:0]              w_pc_src_nxt;

  // Memory-wait bookkeeping: timeout fires on the wait cycle that drives the counter to all-ones
  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_wait_inc   = r_wait + WAIT_WIDTH'(1);
  assign w_timeout    = w_wait_state && !i_mem_ready && (&w_wait_inc);

  // Next-state selection, then Moore decode of the state being entered
  always_comb begin
    w_state_nxt      = S_FETCH;
    w_retire         = 1'b0;
    w_illegal        = 1'b0;
    w_iord_nxt       = 1'b0;
    w_mem_write_nxt  = 1'b0;
    w_reg_dst_nxt    = 1'b0;
    w_mem_to_reg_nxt = 1'b0;
    w_reg_write_nxt  = 1'b0;
    w_alu_src_a_nxt  = 1'b0;
    w_alu_src_b_nxt  = SRCB_RT;
    w_alu_op_nxt     = ALU_ADD;
    w_pc_src_nxt     = 2'b00;

    case (r_state)
      S_RESET:  w_state_nxt = S_FETCH;
      S_FETCH:  w_state_nxt = i_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (i_opcode)
          OP_LW, OP_SW: w_state_nxt = S_MEMADR;
          OP_R:         w_state_nxt = S_EXEC;
          OP_ADDI:      w_state_nxt = S_ADDIEX;
          OP_BEQ:       w_state_nxt = S_BEQ;
          OP_J:         w_state_nxt = S_JUMP;
          default: begin
            w_state_nxt = S_FETCH;
            w_illegal   = 1'b1;
          end
        endcase
      end
      S_MEMADR: w_state_nxt = r_is_sw ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (i_mem_ready)    w_state_nxt = S_MEMWB;
        else if (w_timeout) w_state_nxt = S_FETCH;
        else                w_state_nxt = S_MEMRD;
      end
      S_MEMWB: begin
        w_state_nxt = S_FETCH;
        w_retire    = 1'b1;
      end
      S_MEMWR: begin
        if (i_mem_ready) begin
          w_state_nxt = S_FETCH;
          w_retire    = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_MEMWR;
        end
      end
      S_EXEC:   w_state_nxt = S_ALUWB;
      S_ADDIEX: w_state_nxt = S_ADDIWB;
      S_ALUWB, S_ADDIWB, S_BEQ, S_JUMP: begin
        w_state_nxt = S_FETCH;
        w_retire    = 1'b1;
      end
      default:  w_state_nxt = S_FETCH;
    endcase

    case (w_state_nxt)
      S_FETCH:  w_alu_src_b_nxt = SRCB_FOUR;
      S_DECODE: w_alu_src_b_nxt = SRCB_IMMX4;
      S_MEMADR: begin
        w_alu_src_a_nxt = 1'b1;
        w_alu_src_b_nxt = SRCB_IMM;
      end
      S_MEMRD:  w_iord_nxt = 1'b1;
      S_MEMWB: begin
        w_mem_to_reg_nxt = 1'b1;
        w_reg_write_nxt  = 1'b1;
      end
      S_MEMWR: begin
        w_iord_nxt      = 1'b1;
        w_mem_write_nxt = 1'b1;
      end
      S_EXEC: begin
        w_alu_src_a_nxt = 1'b1;
        w_alu_op_nxt    = ALU_FUNCT;
      end
      S_ALUWB: begin
        w_reg_dst_nxt   = 1'b1;
        w_reg_write_nxt = 1'b1;
      end
      S_ADDIEX: begin
        w_alu_src_a_nxt = 1'b1;
        w_alu_src_b_nxt = SRCB_IMM;
      end
      S_ADDIWB: w_reg_write_nxt = 1'b1;
      S_BEQ: begin
        w_alu_src_a_nxt = 1'b1;
        w_alu_op_nxt    = ALU_SUB;
        w_pc_src_nxt    = PCSRC_ALUOUT;
      end
      S_JUMP:   w_pc_src_nxt = PCSRC_JUMP;
      default:  ;
    endcase
  end

  // State, wait counter, decoded-opcode flag and registered strobes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_RESET;
      r_wait       <= '0;
      r_is_sw      <= 1'b0;
      r_iord       <= 1'b0;
      r_mem_write  <= 1'b0;
      r_reg_dst    <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_reg_write  <= 1'b0;
      r_alu_src_a  <= 1'b0;
      r_alu_src_b  <= 2'b00;
      r_alu_op     <= '0;
      r_pc_src     <= 2'b00;
      r_instr_done <= 1'b0;
      r_illegal_op <= 1'b0;
      r_mem_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wait       <= (w_wait_state && !i_mem_ready && !w_timeout) ? w_wait_inc : '0;
      if (r_state == S_DECODE) begin
        r_is_sw <= (i_opcode == OP_SW);
      end
      r_iord       <= w_iord_nxt;
      r_mem_write  <= w_mem_write_nxt;
      r_reg_dst    <= w_reg_dst_nxt;
      r_mem_to_reg <= w_mem_to_reg_nxt;
      r_reg_write  <= w_reg_write_nxt;
      r_alu_src_a  <= w_alu_src_a_nxt;
      r_alu_src_b  <= w_alu_src_b_nxt;
      r_alu_op     <= w_alu_op_nxt;
      r_pc_src     <= w_pc_src_nxt;
      r_instr_done <= w_retire;
      r_illegal_op <= w_illegal;
      r_mem_err    <= r_mem_err | w_timeout;
    end
  end

  // PC and IR enables follow the live handshake/flag inputs in their state
  assign o_ir_write_c = (r_state == S_FETCH) && i_mem_ready;
  assign o_pc_en_c    = o_ir_write_c || ((r_state == S_BEQ) && i_zero) || (r_state == S_JUMP);

  assign o_iord       = r_iord;
  assign o_mem_write  = r_mem_write;
  assign o_reg_dst    = r_reg_dst;
  assign o_mem_to_reg = r_mem_to_reg;
  assign o_reg_write  = r_reg_write;
  assign o_alu_src_a  = r_alu_src_a;
  assign o_alu_src_b  = r_alu_src_b;
  assign o_alu_op     = r_alu_op;
  assign o_pc_src     = r_pc_src;
  assign o_instr_done = r_instr_done;
  assign o_illegal_op = r_illegal_op;
  assign o_mem_err    = r_mem_err;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: instruction-level model expands each instruction into its
// per-cycle control vector; one loop drives inputs and compares every cycle.
module tb_multicycle_control_fsm;

  localparam int unsigned WAIT_W = 3;
  localparam int          TMO    = 7;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;
  localparam logic [5:0] SWAP    = 6'b001000;

  localparam int ST_RST = 0, ST_IDLE = 1, ST_FETCH = 2, ST_DEC = 3, ST_ADR = 4, ST_RD = 5;
  localparam int ST_MWB = 6, ST_WR = 7, ST_EX = 8, ST_AWB = 9, ST_IEX = 10, ST_IWB = 11;
  localparam int ST_BEQ = 12, ST_JMP = 13;

  typedef struct {
    bit          rst_n;
    bit          rdy;
    bit          zero;
    logic [5:0]  opc;
    logic [16:0] exp;
    bit          lit_en;
    logic [16:0] lit;
    string       nm;
  } cyc_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic       instr_done, illegal_op, mem_err;

  cyc_t q[$];
  bit   m_done, m_ill, m_err;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.OPCODE_WIDTH(6), .ALU_OP_WIDTH(2), .WAIT_WIDTH(WAIT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_zero(zero), .i_mem_ready(mem_ready),
    .o_pc_en_c(pc_en), .o_iord(iord), .o_mem_write(mem_write), .o_ir_write_c(ir_write),
    .o_reg_dst(reg_dst), .o_mem_to_reg(mem_to_reg), .o_reg_write(reg_write),
    .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b), .o_alu_op(alu_op), .o_pc_src(pc_src),
    .o_instr_done(instr_done), .o_illegal_op(illegal_op), .o_mem_err(mem_err)
  );

  // Control vector for one microstep, straight from the per-step strobe table
  function automatic logic [16:0] ctrl(int st, bit rdy, bit z);
    logic pcen, io, mw, irw, rd, m2r, rw, sa;
    logic [1:0] sb, aop, ps;
    {pcen, io, mw, irw, rd, m2r, rw, sa} = 8'h00;
    sb = 2'b00; aop = 2'b00; ps = 2'b00;
    case (st)
      ST_FETCH: begin sb = 2'b01; irw = rdy; pcen = rdy; end
      ST_DEC:   sb = 2'b11;
      ST_ADR:   begin sa = 1'b1; sb = 2'b10; end
      ST_RD:    io = 1'b1;
      ST_MWB:   begin m2r = 1'b1; rw = 1'b1; end
      ST_WR:    begin io = 1'b1; mw = 1'b1; end
      ST_EX:    begin sa = 1'b1; aop = 2'b10; end
      ST_AWB:   begin rd = 1'b1; rw = 1'b1; end
      ST_IEX:   begin sa = 1'b1; sb = 2'b10; end
      ST_IWB:   rw = 1'b1;
      ST_BEQ:   begin sa = 1'b1; aop = 2'b01; ps = 2'b01; pcen = z; end
      ST_JMP:   begin ps = 2'b10; pcen = 1'b1; end
      default:  ;
    endcase
    return {pcen, io, mw, irw, rd, m2r, rw, sa, sb, aop, ps, 3'b000};
  endfunction

  task automatic push(int st, bit rdy, bit z, logic [5:0] opc, string nm);
    cyc_t c;
    c.rst_n  = (st != ST_RST);
    c.rdy    = rdy;
    c.zero   = z;
    c.opc    = opc;
    c.lit_en = 1'b0;
    c.lit    = '0;
    c.nm     = nm;
    if (st == ST_RST) begin
      c.exp  = '0;
      m_done = 1'b0;
      m_ill  = 1'b0;
      m_err  = 1'b0;
    end else begin
      c.exp  = ctrl(st, rdy, z) | {14'b0, m_done, m_ill, m_err};
      m_done = 1'b0;
      m_ill  = 1'b0;
    end
    q.push_back(c);
  endtask

  task automatic lit_at(int idx, logic [16:0] v);
    cyc_t c;
    c = q[idx];
    c.lit_en = 1'b1;
    c.lit    = v;
    q[idx]   = c;
  endtask

  task automatic reset(int n);
    for (int i = 0; i < n; i++) push(ST_RST, 1'b1, 1'b0, OP_BAD, "reset");
    push(ST_IDLE, 1'b1, 1'b1, OP_BAD, "post_reset");
  endtask

  // Fetch stalls; every TMO consecutive waits is a timeout that restarts the fetch
  task automatic fetch(logic [5:0] opc, int waits);
    for (int i = 1; i <= waits; i++) begin
      push(ST_FETCH, 1'b0, 1'b1, opc ^ SWAP, "fetch_wait");
      if (i % TMO == 0) m_err = 1'b1;
    end
    push(ST_FETCH, 1'b1, 1'b1, opc ^ SWAP, "fetch");
  endtask

  task automatic mem(int st, logic [5:0] opc, int waits, output bit ab);
    int n;
    n  = (waits >= TMO) ? TMO : waits;
    ab = 1'b0;
    for (int i = 0; i < n; i++) push(st, 1'b0, 1'b1, opc ^ SWAP, "mem_wait");
    if (waits >= TMO) begin
      m_err = 1'b1;
      ab    = 1'b1;
    end else begin
      push(st, 1'b1, 1'b1, opc ^ SWAP, "mem");
    end
  endtask

  task automatic instr(logic [5:0] opc, int fw, int mw, bit z);
    bit ab;
    logic [5:0] ox;
    ox = opc ^ SWAP;
    fetch(opc, fw);
    push(ST_DEC, 1'b0, 1'b1, opc, "decode");
    case (opc)
      OP_LW: begin
        push(ST_ADR, 1'b0, 1'b1, ox, "lw_adr");
        mem(ST_RD, opc, mw, ab);
        if (!ab) begin
          push(ST_MWB, 1'b0, 1'b1, ox, "lw_wb");
          m_done = 1'b1;
        end
      end
      OP_SW: begin
        push(ST_ADR, 1'b0, 1'b1, ox, "sw_adr");
        mem(ST_WR, opc, mw, ab);
        if (!ab) m_done = 1'b1;
      end
      OP_R: begin
        push(ST_EX, 1'b0, 1'b1, ox, "r_exec");
        push(ST_AWB, 1'b0, 1'b1, ox, "r_wb");
        m_done = 1'b1;
      end
      OP_ADDI: begin
        push(ST_IEX, 1'b0, 1'b1, ox, "addi_exec");
        push(ST_IWB, 1'b0, 1'b1, ox, "addi_wb");
        m_done = 1'b1;
      end
      OP_BEQ: begin
        push(ST_BEQ, 1'b0, z, ox, "beq");
        m_done = 1'b1;
      end
      OP_J: begin
        push(ST_JMP, 1'b0, 1'b1, ox, "jump");
        m_done = 1'b1;
      end
      default: m_ill = 1'b1;
    endcase
  endtask

  task automatic build();
    int k;
    reset(3);
    lit_at(q.size() - 1, 17'h00000);
    k = q.size(); instr(OP_LW, 0, 0, 1'b0);
    lit_at(k, 17'h12080); lit_at(k + 3, 17'h08000); lit_at(k + 4, 17'h00C00);
    k = q.size(); instr(OP_BEQ, 0, 0, 1'b1);
    lit_at(k, 17'h12084); lit_at(k + 2, 17'h10228);
    k = q.size(); instr(OP_BEQ, 0, 0, 1'b0);
    lit_at(k + 2, 17'h00228);
    k = q.size(); instr(OP_SW, 0, 5, 1'b0);
    lit_at(k + 3, 17'h0C000); lit_at(k + 8, 17'h0C000);
    instr(OP_R, 0, 0, 1'b0);
    instr(OP_ADDI, 0, 0, 1'b0);
    instr(OP_J, 0, 0, 1'b0);
    instr(OP_BAD, 0, 0, 1'b0);
    k = q.size(); instr(OP_R, 0, 0, 1'b0);
    lit_at(k, 17'h12082);
    instr(OP_LW, 2, 3, 1'b0);
    fetch(OP_LW, 0);
    push(ST_DEC, 1'b0, 1'b1, OP_LW, "abort_dec");
    push(ST_ADR, 1'b0, 1'b1, OP_LW ^ SWAP, "abort_adr");
    reset(2);
    k = q.size(); instr(OP_R, 9, 0, 1'b0);
    lit_at(k + 7, 17'h00081);
    instr(OP_SW, 0, 7, 1'b0);
    k = q.size(); instr(OP_J, 0, 0, 1'b0);
    lit_at(k, 17'h12081);
    instr(OP_LW, 0, 1, 1'b0);
    reset(3);
    k = q.size(); instr(OP_ADDI, 0, 0, 1'b0);
    lit_at(k, 17'h12080);
    fetch(OP_R, 0);
  endtask

  initial begin
    cyc_t        c;
    logic [16:0] act;
    int          cyc;
    rst_n     = 1'b1;
    mem_ready = 1'b0;
    zero      = 1'b0;
    opcode    = 6'b000000;
    cyc       = 0;
    build();
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      rst_n     = c.rst_n;
      mem_ready = c.rdy;
      zero      = c.zero;
      opcode    = c.opc;
      #1;
      act = {pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
             alu_src_b, alu_op, pc_src, instr_done, illegal_op, mem_err};
      checks++;
      if (act !== c.exp) begin
        errors++;
        $display("FAIL %s cycle %0d got %05h want %05h", c.nm, cyc, act, c.exp);
      end
      if (c.lit_en) begin
        checks++;
        if (act !== c.lit) begin
          errors++;
          $display("FAIL %s_pinned cycle %0d got %05h want %05h", c.nm, cyc, act, c.lit);
        end
      end
      cyc++;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
